// File: rtl/rr_arb_2port_fifo_mux.sv
// Two input FIFOs merged onto one stream by a round-robin arbiter with a stall-time grant lock.
// Optional build macro RR_ARB_OUT_REG_EN adds an output register stage (latency 2 instead of 1).
module rr_arb_2port_fifo_mux #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in0_valid,
  output logic          in0_ready,
  input  logic [W-1:0]  in0_data,
  input  logic          in1_valid,
  output logic          in1_ready,
  input  logic [W-1:0]  in1_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_id,
  output logic [LW-1:0] level0,
  output logic [LW-1:0] level1
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]  mem_q [2][DEPTH];
  logic [PW-1:0] wp_q  [2];
  logic [PW-1:0] rp_q  [2];
  logic [LW-1:0] lvl_q [2];
  logic [W-1:0]  din_s [2];
  logic          nxt_q;
  logic [1:0]    vld_s, rdy_s, wr_s, cand_s, pop_s;
  logic          gid_s;
  logic [W-1:0]  head_s;

  function automatic logic rr_pick(input logic [1:0] cand, input logic nxt);
    logic id;
    case (cand)
      2'b11:   id = nxt;
      2'b10:   id = 1'b1;
      default: id = 1'b0;
    endcase
    return id;
  endfunction

  // Ready is forced low during reset and never looks ahead to a same-cycle pop.
  assign rdy_s     = {rst_n && (lvl_q[1] != FULL_LVL), rst_n && (lvl_q[0] != FULL_LVL)};
  assign cand_s    = {lvl_q[1] != {LW{1'b0}}, lvl_q[0] != {LW{1'b0}}};
  assign vld_s     = {in1_valid, in0_valid};
  assign wr_s      = vld_s & rdy_s;
  assign din_s[0]  = in0_data;
  assign din_s[1]  = in1_data;
  assign in0_ready = rdy_s[0];
  assign in1_ready = rdy_s[1];
  assign level0    = lvl_q[0];
  assign level1    = lvl_q[1];
  assign head_s    = mem_q[gid_s][rp_q[gid_s]];

`ifdef RR_ARB_OUT_REG_EN
  logic         ov_q, oid_q, load_s;
  logic [W-1:0] od_q;

  assign gid_s     = rr_pick(cand_s, nxt_q);
  assign load_s    = !ov_q || out_ready;
  assign pop_s     = (load_s && (|cand_s)) ? (gid_s ? 2'b10 : 2'b01) : 2'b00;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_id    = oid_q;

  // Output stage: refills whenever empty or being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q  <= 1'b0;
      od_q  <= {W{1'b0}};
      oid_q <= 1'b0;
    end else if (load_s) begin
      ov_q <= |cand_s;
      if (|cand_s) begin
        od_q  <= head_s;
        oid_q <= gid_s;
      end
    end
  end
`else
  logic lock_vld_q, lock_id_q;

  assign gid_s     = lock_vld_q ? lock_id_q : rr_pick(cand_s, nxt_q);
  assign out_valid = |cand_s;
  assign out_id    = out_valid & gid_s;
  assign out_data  = out_valid ? head_s : {W{1'b0}};
  assign pop_s     = (out_valid && out_ready) ? (gid_s ? 2'b10 : 2'b01) : 2'b00;

  // Freeze the grant while the downstream stalls so a late arrival cannot steal it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld_q <= 1'b0;
      lock_id_q  <= 1'b0;
    end else begin
      lock_vld_q <= out_valid && !out_ready;
      lock_id_q  <= gid_s;
    end
  end
`endif

  // FIFO pointers, levels and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        wp_q[p]  <= {PW{1'b0}};
        rp_q[p]  <= {PW{1'b0}};
        lvl_q[p] <= {LW{1'b0}};
      end
      nxt_q <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (wr_s[p])  wp_q[p] <= wp_q[p] + PW'(1'b1);
        if (pop_s[p]) rp_q[p] <= rp_q[p] + PW'(1'b1);
        lvl_q[p] <= lvl_q[p] + LW'(wr_s[p]) - LW'(pop_s[p]);
      end
      if (|pop_s) nxt_q <= ~gid_s;
    end
  end

  // Storage array; writes are already gated off during reset.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (wr_s[p]) mem_q[p][wp_q[p]] <= din_s[p];
    end
  end
endmodule

// File: tb/tb_rr_arb_2port_fifo_mux.sv
// Scoreboard bench for rr_arb_2port_fifo_mux; adapts latency/capacity to RR_ARB_OUT_REG_EN.
module tb_rr_arb_2port_fifo_mux;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef RR_ARB_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int CAP = DEPTH + LAT - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in0_valid, in1_valid, out_ready;
  logic          in0_ready, in1_ready, out_valid, out_id;
  logic [W-1:0]  in0_data, in1_data, out_data;
  logic [LW-1:0] level0, level1;

  typedef struct packed { logic id; logic [W-1:0] data; } exp_t;
  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  rr_arb_2port_fifo_mux #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .level0(level0), .level1(level1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic expect_word(input logic id, input logic [W-1:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    rst_n = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    in0_data = 8'h00; in1_data = 8'h00;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(output int cyc);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 40) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check_eq("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: every transfer must match the next expected word.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_word", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_id", 32'(out_id), 32'(e.id));
        check_eq("sb_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    in0_data = 8'h00; in1_data = 8'h00;

    // Reset state
    @(negedge clk);
    check_eq("rst_in0_ready", 32'(in0_ready), 32'd0);
    check_eq("rst_in1_ready", 32'(in1_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_id",    32'(out_id),    32'd0);
    check_eq("rst_out_data",  32'(out_data),  32'd0);
    check_eq("rst_level0",    32'(level0),    32'd0);
    check_eq("rst_level1",    32'(level1),    32'd0);
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in0_ready", 32'(in0_ready), 32'd1);
    check_eq("post_rst_in1_ready", 32'(in1_ready), 32'd1);
    check_eq("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Single word latency
    reset_dut;
    out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 8'hA1;
    expect_word(1'b0, 8'hA1);
    tick;
    in0_valid = 1'b0;
    repeat (LAT - 1) tick;
    @(negedge clk);
    check_eq("t1_out_valid", 32'(out_valid), 32'd1);
    check_eq("t1_out_data",  32'(out_data),  32'hA1);
    check_eq("t1_out_id",    32'(out_id),    32'd0);
    check_eq("t1_level_mid", 32'(level0),    (LAT == 1) ? 32'd1 : 32'd0);
    tick;
    wait_drain(cyc);
    tick;
    @(negedge clk);
    check_eq("t1_level_end", 32'(level0),    32'd0);
    check_eq("t1_idle",      32'(out_valid), 32'd0);

    // Round-robin alternation at full throughput
    reset_dut;
    in0_valid = 1'b1; in1_valid = 1'b1; in0_data = 8'h10; in1_data = 8'h20;
    expect_word(1'b0, 8'h10); expect_word(1'b1, 8'h20);
    expect_word(1'b0, 8'h11); expect_word(1'b1, 8'h21);
    tick;
    in0_data = 8'h11; in1_data = 8'h21;
    tick;
    in0_valid = 1'b0; in1_valid = 1'b0;
    tick;
    @(negedge clk);
    check_eq("t2_first_id",   32'(out_id),   32'd0);
    check_eq("t2_first_data", 32'(out_data), 32'h10);
    tick;
    out_ready = 1'b1;
    wait_drain(cyc);
    check_eq("t2_cycles", 32'(cyc), 32'd4);

    // Full FIFO back-pressure on port 1
    reset_dut;
    for (int i = 0; i < CAP; i++) begin
      in1_valid = 1'b1; in1_data = 8'(8'hB0 + i);
      expect_word(1'b1, 8'(8'hB0 + i));
      tick;
    end
    in1_data = 8'hEE;
    @(negedge clk);
    check_eq("t3_level_full", 32'(level1),    32'(DEPTH));
    check_eq("t3_ready_full", 32'(in1_ready), 32'd0);
    tick; tick;
    in1_valid = 1'b0;
    @(negedge clk);
    check_eq("t3_level_hold", 32'(level1), 32'(DEPTH));
    tick;
    out_ready = 1'b1;
    wait_drain(cyc);
    repeat (3) tick;
    @(negedge clk);
    check_eq("t3_idle",       32'(out_valid), 32'd0);
    check_eq("t3_level_end",  32'(level1),    32'd0);

    // Grant lock while stalled
    reset_dut;
    in1_valid = 1'b1; in1_data = 8'h55;
    expect_word(1'b1, 8'h55);
    tick;
    in1_valid = 1'b0;
    in0_valid = 1'b1; in0_data = 8'h66;
    expect_word(1'b0, 8'h66);
    tick;
    in0_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("t4_lock_valid", 32'(out_valid), 32'd1);
      check_eq("t4_lock_id",    32'(out_id),    32'd1);
      check_eq("t4_lock_data",  32'(out_data),  32'h55);
      tick;
    end
    out_ready = 1'b1;
    wait_drain(cyc);

    // Full FIFO 0 with simultaneous pop: no write-through
    reset_dut;
    for (int i = 0; i < CAP; i++) begin
      in0_valid = 1'b1; in0_data = 8'(8'hC0 + i);
      expect_word(1'b0, 8'(8'hC0 + i));
      tick;
    end
    in0_data = 8'hD0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("t5_ready_full", 32'(in0_ready), 32'd0);
    check_eq("t5_level_full", 32'(level0),    32'(DEPTH));
    tick;
    @(negedge clk);
    check_eq("t5_ready_next", 32'(in0_ready), 32'd1);
    check_eq("t5_level_next", 32'(level0),    32'(DEPTH - 1));
    expect_word(1'b0, 8'hD0);
    tick;
    in0_valid = 1'b0;
    wait_drain(cyc);

    // Asynchronous reset with buffered words
    reset_dut;
    in0_valid = 1'b1; in1_valid = 1'b1; in0_data = 8'hE0; in1_data = 8'hE8;
    tick;
    in1_valid = 1'b0; in0_data = 8'hE1;
    tick;
    in0_valid = 1'b0;
    tick;
    @(negedge clk);
    check_eq("t6_buffered", 32'(level0) + 32'(level1), 32'(3 - (LAT - 1)));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_level0", 32'(level0),    32'd0);
    check_eq("t6_rst_level1", 32'(level1),    32'd0);
    check_eq("t6_rst_valid",  32'(out_valid), 32'd0);
    check_eq("t6_rst_ready",  32'(in0_ready), 32'd0);
    tick;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("t6_no_stale", 32'(out_valid), 32'd0);
      tick;
    end
    in1_valid = 1'b1; in1_data = 8'h77;
    expect_word(1'b1, 8'h77);
    tick;
    in1_valid = 1'b0;
    wait_drain(cyc);
    repeat (2) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_arb_2port_fifo_mux.md
RR_ARB_2PORT_FIFO_MUX -- requirements
Module: rr_arb_2port_fifo_mux

Interface
REQ-001 Parameter W, default 8, payload width in bits (W >= 1).
REQ-002 Parameter DEPTH, default 4, entries per input FIFO (power of 2, >= 2); LW = $clog2(DEPTH)+1.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in0_valid / in1_valid  input  1  upstream port 0/1 offers a word.
REQ-006 in0_ready / in1_ready  output  1  port 0/1 FIFO accepts this cycle.
REQ-007 in0_data / in1_data  input  W  port 0/1 payload.
REQ-008 out_valid  output  1  downstream word available.
REQ-009 out_ready  input  1  downstream accepts.
REQ-010 out_data  output  W  granted payload.
REQ-011 out_id  output  1  source port of out_data (0 or 1).
REQ-012 level0 / level1  output  LW  current occupancy of FIFO 0/1.

Function
REQ-013 Port i write occurs iff ini_valid && ini_ready at the clock edge; ini_ready SHALL equal !full_i (no write-through when full), and SHALL be 0 while rst_n is low.
REQ-014 Each FIFO is first-in first-out; same-cycle write and read of one FIFO SHALL both take effect when not full, level unchanged.
REQ-015 A word written at edge N SHALL be visible at the arbiter from cycle N+1 (no bypass around an empty FIFO).
REQ-016 Arbiter candidates: non-empty FIFOs; one candidate wins unconditionally; two candidates -> port named by pointer nxt wins.
REQ-017 nxt SHALL update only on a grant taken (FIFO pop): nxt <= 1 after popping port 0, nxt <= 0 after popping port 1; otherwise hold.
REQ-018 Once out_valid is 1 with out_ready 0, out_data and out_id SHALL hold stable until transfer, even if the other FIFO becomes non-empty (grant lock register).
REQ-019 Transfer (out_valid && out_ready) SHALL pop exactly one word from the port in out_id.
REQ-020 level0/level1 SHALL range 0..DEPTH, full_i at DEPTH, empty_i at 0; read/write pointers wrap modulo DEPTH.
REQ-021 Sustained traffic on both ports with out_ready=1 SHALL alternate out_id 0,1,0,1 with one transfer per cycle.

Reset
REQ-022 On rst_n low (asynchronous): both FIFOs empty, levels 0, nxt = 0, grant lock cleared, out_valid = 0, out_id = 0, out_data = 0 (registered paths).
REQ-023 Reset asserted mid-transfer SHALL discard all buffered words; no word accepted while rst_n low is ever output.
REQ-024 First cycle after deassertion: in0_ready = in1_ready = 1, out_valid = 0.

Configuration
REQ-025 Macro RR_ARB_OUT_REG_EN defined: out_valid/out_data/out_id come from an output register loaded when empty or when out_ready=1; the pop and nxt update occur on register load; lock of REQ-018 is provided by the register; input-to-output latency = 2 cycles.
REQ-026 Macro RR_ARB_OUT_REG_EN undefined: outputs driven combinationally from FIFO heads via the grant mux; pop on transfer; input-to-output latency = 1 cycle; throughput 1 word/cycle in both builds.

Verification
REQ-027 Reset, then in0 writes 0xA1 only, out_ready=1 -> out_valid one cycle later (two with macro), out_data=0xA1, out_id=0, level0 returns to 0.
REQ-028 Preload both FIFOs (0x10,0x11 on port 0; 0x20,0x21 on port 1), then out_ready=1 -> output order 0x10,0x20,0x11,0x21, out_id 0,1,0,1.
REQ-029 out_ready=0, write DEPTH=4 words to port 1 -> level1=4, in1_ready=0 next cycle; fifth valid not accepted; then drain -> exactly 4 words, in order.
REQ-030 Only port 1 pending with out_ready=0, then port 0 becomes non-empty while stalled -> out_id stays 1 and out_data unchanged until out_ready=1.
REQ-031 Full FIFO 0 with in0_valid=1 and out_ready=1 same cycle -> word popped, new word not accepted that cycle (in0_ready=0), accepted next cycle.
REQ-032 Assert rst_n low with 3 words buffered -> levels 0 and out_valid 0 immediately; after release no stale word appears.
